serial_sum_collector: RTL and testbench

SERIAL_SUM_COLLECTOR -- requirements
Module: serial_sum_collector

---
 rtl/serial_sum_collector_pkg.sv | 13 +
 rtl/serial_sum_collector_sipo_shift_reg.sv | 31 +++
 rtl/serial_sum_collector.sv | 153 +++++++++++++++
 tb/tb_serial_sum_collector.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sum_collector_pkg.sv
// Shared types and constants for the serial sum collector.
// The optional parity output is enabled by defining SERIAL_SUM_PARITY_EN.
package serial_sum_collector_pkg;

    localparam int SER_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sum_collector_sipo_shift_reg.sv
// Serial-in/parallel-out shift register: shifts right, new bit enters the MSB.
// Synchronous clear has priority over shift; async active-low reset.
module sipo_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Shift register state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r <= '0;
        end else if (clr) begin
            q_r <= '0;
        end else if (shift_en) begin
            q_r <= {din, q_r[WIDTH-1:1]};
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/serial_sum_collector.sv
// Collects a bit-serial adder's sum (LSB first) into a parallel result with handshake.
// Define SERIAL_SUM_PARITY_EN to add the registered parity output.
module serial_sum_collector
    import serial_sum_collector_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             sum_bit,
    input  logic             carry_bit,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             out_valid,
    output logic             busy,
`ifdef SERIAL_SUM_PARITY_EN
    output logic             parity,
`endif
    output logic             overrun
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state_r, state_nxt_s;
    logic [CW-1:0]    cnt_r, cnt_nxt_s;
    logic             carry_r, carry_nxt_s;
    logic             ovr_r, ovr_nxt_s;
    logic             clr_s, shift_s, hold_entry_s;
    logic [WIDTH-1:0] shreg_q_s;

    sipo_shift_reg #(.WIDTH(WIDTH)) u_sipo (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_s),
        .shift_en (shift_s),
        .din      (sum_bit),
        .q        (shreg_q_s)
    );

    // Next-state and datapath control; start always wins over a same-cycle bit
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        carry_nxt_s  = carry_r;
        ovr_nxt_s    = 1'b0;
        clr_s        = 1'b0;
        shift_s      = 1'b0;
        hold_entry_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = COLLECT;
                    clr_s       = 1'b1;
                    cnt_nxt_s   = '0;
                    carry_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            COLLECT: begin
                if (start) begin
                    clr_s       = 1'b1;
                    cnt_nxt_s   = '0;
                    carry_nxt_s = 1'b0;
                    ovr_nxt_s   = 1'b1;
                end else if (bit_valid) begin
                    shift_s = 1'b1;
                    if (cnt_r == LAST_IDX) begin
                        state_nxt_s  = HOLD;
                        carry_nxt_s  = carry_bit;
                        cnt_nxt_s    = '0;
                        hold_entry_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        state_nxt_s = COLLECT;
                        clr_s       = 1'b1;
                        cnt_nxt_s   = '0;
                        carry_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (start) begin
                    ovr_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                clr_s       = 1'b1;
                cnt_nxt_s   = '0;
                carry_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counter, carry and overrun registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            carry_r <= carry_nxt_s;
            ovr_r   <= ovr_nxt_s;
        end
    end

`ifdef SERIAL_SUM_PARITY_EN
    function automatic logic calc_parity(input logic [WIDTH-1:0] data, input logic c);
        return (^data) ^ c;
    endfunction

    logic par_r;

    // Parity is formed from the value about to be registered on HOLD entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_r <= 1'b0;
        end else if (clr_s) begin
            par_r <= 1'b0;
        end else if (hold_entry_s) begin
            par_r <= calc_parity({sum_bit, shreg_q_s[WIDTH-1:1]}, carry_bit);
        end else begin
            par_r <= par_r;
        end
    end

    assign parity = par_r;
`endif

    assign result    = shreg_q_s;
    assign carry_out = carry_r;
    assign out_valid = (state_r == HOLD);
    assign busy      = (state_r == COLLECT);
    assign overrun   = ovr_r;

endmodule

// File: tb/tb_serial_sum_collector.sv
// Randomized and directed bench for serial_sum_collector against a word-level model.
// Parity checks are compiled in when SERIAL_SUM_PARITY_EN is defined.
module tb_serial_sum_collector;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, bit_valid, sum_bit, carry_bit, out_ready;
    logic [W-1:0] result;
    logic         carry_out, out_valid, busy, overrun;
`ifdef SERIAL_SUM_PARITY_EN
    logic         parity;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    serial_sum_collector #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .sum_bit   (sum_bit),
        .carry_bit (carry_bit),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .out_valid (out_valid),
        .busy      (busy),
`ifdef SERIAL_SUM_PARITY_EN
        .parity    (parity),
`endif
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start     = 1'b1;
        bit_valid = 1'($urandom);
        sum_bit   = 1'($urandom);
        step();
        start = 1'b0;
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_ovr", 32'(overrun), 32'd0);
        check_eq("start_ov", 32'(out_valid), 32'd0);
    endtask

    // gap_mode: 0 none, 1 alternate idle cycles, 2 random idle cycles
    task automatic send_bits(input logic [W-1:0] v, input logic c, input int gap_mode);
        for (int i = 0; i < W; i++) begin
            if (gap_mode == 1 || (gap_mode == 2 && ($urandom_range(0, 1) == 1))) begin
                bit_valid = 1'b0;
                sum_bit   = 1'($urandom);
                carry_bit = 1'($urandom);
                step();
                check_eq("gap_busy", 32'(busy), 32'd1);
            end
            bit_valid = 1'b1;
            sum_bit   = v[i];
            carry_bit = (i == W - 1) ? c : 1'($urandom);
            step();
            if (i < W - 1) begin
                check_eq("mid_ov", 32'(out_valid), 32'd0);
            end else begin
                check_eq("lat_ov", 32'(out_valid), 32'd1);
                check_eq("lat_result", 32'(result), 32'(v));
                check_eq("lat_carry", 32'(carry_out), 32'(c));
                check_eq("lat_busy", 32'(busy), 32'd0);
`ifdef SERIAL_SUM_PARITY_EN
                check_eq("parity", 32'(parity), 32'(($countones(v) + int'(c)) % 2));
`endif
            end
        end
        bit_valid = 1'b0;
    endtask

    // Hold with out_ready low for d cycles (junk bit_valid must be ignored), then accept
    task automatic drain(input logic [W-1:0] v, input logic c, input int d);
        for (int k = 0; k < d; k++) begin
            out_ready = 1'b0;
            bit_valid = 1'($urandom);
            sum_bit   = 1'($urandom);
            step();
            check_eq("hold_ov", 32'(out_valid), 32'd1);
            check_eq("hold_result", 32'(result), 32'(v));
            check_eq("hold_carry", 32'(carry_out), 32'(c));
        end
        out_ready = 1'b1;
        bit_valid = 1'b0;
        step();
        out_ready = 1'b0;
        check_eq("drain_ov", 32'(out_valid), 32'd0);
        check_eq("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] v;
        logic         c;
        rst = 1'b0; start = 1'b0; bit_valid = 1'b0; sum_bit = 1'b0;
        carry_bit = 1'b0; out_ready = 1'b0;
        repeat (2) step();
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_ov", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_carry", 32'(carry_out), 32'd0);
        check_eq("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b1;
        step();

        // Normal sum 0xCD + 0xC4 = 0x191
        do_start();
        send_bits(8'h91, 1'b1, 0);
        drain(8'h91, 1'b1, 0);

        // Backpressure for 5 cycles
        do_start();
        send_bits(8'h91, 1'b1, 0);
        drain(8'h91, 1'b1, 5);

        // Gapped input
        do_start();
        send_bits(8'h5A, 1'b0, 1);
        drain(8'h5A, 1'b0, 0);

        // Restart after 3 bits
        do_start();
        v = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1; sum_bit = v[i]; carry_bit = 1'b1;
            step();
        end
        start = 1'b1; bit_valid = 1'b1;
        step();
        start = 1'b0; bit_valid = 1'b0;
        check_eq("restart_ovr", 32'(overrun), 32'd1);
        check_eq("restart_busy", 32'(busy), 32'd1);
        step();
        check_eq("restart_ovr_clr", 32'(overrun), 32'd0);
        send_bits(8'h3C, 1'b0, 0);
        drain(8'h3C, 1'b0, 0);

        // Start in HOLD without ready is dropped; with ready goes straight to COLLECT
        do_start();
        send_bits(8'hA7, 1'b1, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("hold_start_ovr", 32'(overrun), 32'd1);
        check_eq("hold_start_ov", 32'(out_valid), 32'd1);
        check_eq("hold_start_res", 32'(result), 32'hA7);
        start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0; out_ready = 1'b0;
        check_eq("hs_ov", 32'(out_valid), 32'd0);
        check_eq("hs_busy", 32'(busy), 32'd1);
        check_eq("hs_ovr", 32'(overrun), 32'd0);
        send_bits(8'h90, 1'b0, 0);
        drain(8'h90, 1'b0, 1);
        do_start();
        send_bits(8'h01, 1'b0, 0);
        drain(8'h01, 1'b0, 0);

        // Reset mid-COLLECT
        do_start();
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1; sum_bit = 1'b1; carry_bit = 1'b1;
            step();
        end
        #2 rst = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_result", 32'(result), 32'd0);
        step();
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bit_valid = 1'($urandom); sum_bit = 1'($urandom); carry_bit = 1'($urandom);
            out_ready = 1'($urandom);
            step();
            check_eq("post_rst_ov", 32'(out_valid), 32'd0);
            check_eq("post_rst_res", 32'(result), 32'd0);
            check_eq("post_rst_busy", 32'(busy), 32'd0);
        end
        bit_valid = 1'b0; out_ready = 1'b0;

        // Randomized transactions
        for (int t = 0; t < 25; t++) begin
            v = W'($urandom);
            c = 1'($urandom);
            do_start();
            send_bits(v, c, 2);
            drain(v, c, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
